lane_scatter: RTL
=================

# lane_scatter

Streaming lane unpacker: accepts a packed word of LANES lanes (LANE_W bits each) plus a per-lane enable mask, and emits the enabled lanes one at a time, in ascending lane order, on a narrow valid/ready output. It performs the inverse of the bit-gather/concatenate wiring used to build packed array ports. It sits between a packed-array producer and a per-lane consumer that accepts one lane per cycle.

## Interface

Parameters:
- LANE_W, default 4: bits per lane.
- LANES, default 4: lanes per packed word, must be ≥ 2. IDX_W = $clog2(LANES).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  reset, asynchronous, active-low.
- in_valid  input  1  packed word offered.
- in_ready  output  1  block accepts the packed word this cycle.
- in_data  input  LANES*LANE_W  packed word; lane k = in_data[k*LANE_W +: LANE_W].
- in_mask  input  LANES  bit k set means lane k is emitted.
- out_valid  output  1  lane available.
- out_ready  input  1  consumer accepts the lane.
- out_data  output  LANE_W  lane value.
- out_idx  output  IDX_W  lane index k of out_data.
- out_last  output  1  current lane is the final enabled lane of its word.
- drop_cnt  output  8  count of words accepted with an all-zero mask; saturates at 255.

## Operation

- State:
  - word register (LANES*LANE_W bits).
  - remaining-mask register rem (LANES bits).
  - busy = (rem != 0).
  - drop_cnt register.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !busy || (out_valid && out_ready && out_last).
  - On accept, load word ← in_data and rem ← in_mask.
- Output selection, from registered state only:
  - sel = index of the lowest set bit of rem.
  - out_valid = busy.
  - out_data = word lane sel; out_idx = sel.
  - out_last = busy && exactly one bit of rem set.
- Output handshake (out_valid && out_ready) clears rem[sel].
- Simultaneous last-lane handshake and input accept: the load of the new word and mask takes priority over the clear, so there is no bubble between words.
- All-zero mask on accept:
  - The word is dropped; no output is produced.
  - busy stays 0 and in_ready stays 1 the next cycle.
  - drop_cnt increments by 1, saturating at 255 (255 + 1 = 255).
- When out_valid = 0: out_data, out_idx and out_last are 0.
- Stalls: out_valid held high with out_ready low holds out_data, out_idx and out_last stable. Output valid is never retracted before its handshake.
- in_data and in_mask are don't-care when in_valid = 0.

## Timing

- Reset (ASYNCRESETN low), effective immediately regardless of CLK:
  - rem, word and drop_cnt clear to 0.
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, drop_cnt = 0.
  - in_ready = 0 while reset is asserted; in_ready = 1 from the first cycle after deassertion.
- Reset mid-word: remaining lanes are discarded and no lane is emitted after release.
- Latency: a word accepted at edge N presents its first lane in the cycle after edge N.
- Throughput: one lane per cycle with out_ready held high. A word with m enabled lanes occupies m cycles.
- Combinational paths:
  - No combinational path exists from in_* to out_*.
  - in_ready depends combinationally on out_ready and state only.
- Mask popcount 1: out_last = 1 on the word's only lane.
- Mask all-ones: lanes 0..LANES-1 are emitted in order; out_last is high on lane LANES-1 only.

## Test plan

- Reset:
  - Assert ASYNCRESETN low mid-word (mask 4'b1111, after 2 lanes out).
  - Required: outputs go to 0 immediately, without a clock edge.
  - Required after release: in_ready = 1 and no further lanes are emitted.
- Full mask, back-to-back, out_ready held 1:
  - Stimulus: word 16'hA5C3 with mask 4'b1111, then word 16'h1234 with mask 4'b1111.
  - Required (out_data, out_idx, out_last): (3,0,0), (C,1,0), (5,2,0), (A,3,1), then (4,0,0), (3,1,0), (2,2,0), (1,3,1).
  - Required: 8 consecutive valid cycles with no bubble; in_ready = 1 in the cycle A is emitted.
- Sparse mask:
  - Stimulus: word 16'hFEDC with mask 4'b1010.
  - Required: (D,1,0) then (F,3,1).
  - Required: in_ready = 0 while lane 1 is pending.
- Backpressure:
  - Stimulus: word 16'h8421 with mask 4'b0101; out_ready low for 3 cycles.
  - Required: (1,0,0) held stable for all 3 cycles, then (4,2,1).
  - Required: in_ready = 0 throughout the stall.
- Drop:
  - Stimulus: 3 words with mask 4'b0000, then word 16'h0007 with mask 4'b0001.
  - Required: no out_valid for the dropped words; drop_cnt = 3; then (7,0,1).
  - Stimulus: 300 words with mask 4'b0000.
  - Required: drop_cnt = 255 (saturated).
- Single-lane mask:
  - Stimulus: word 16'hB000 with mask 4'b1000, in_valid held high with the next word queued.
  - Required: (B,3,1) in the cycle after accept.
  - Required: the next word's first lane follows in the immediately following cycle.

Source files
------------

// File: rtl/lane_scatter_if.sv
// Handshake bundle for lane_scatter: packed-word input side and per-lane output side.
// The slave modport is the block's view; master is the producer/consumer view.
interface lane_scatter_if #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
);
    localparam int IDX_W = $clog2(LANES);

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*LANE_W-1:0]   in_data;
    logic [LANES-1:0]          in_mask;

    logic                      out_valid;
    logic                      out_ready;
    logic [LANE_W-1:0]         out_data;
    logic [IDX_W-1:0]          out_idx;
    logic                      out_last;

    logic [7:0]                drop_cnt;

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, drop_cnt
    );

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, drop_cnt
    );
endinterface

// File: rtl/lane_scatter.sv
// Streaming lane unpacker: emits the enabled lanes of a packed word one per cycle,
// lowest lane first, with the next word loaded on the last lane's handshake.
module lane_scatter_pick #(
    parameter int LANE_W = 4,
    parameter int IDX_W  = 2,
    parameter int IDX    = 0
) (
    input  logic              hot_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [LANE_W-1:0] data_o,
    output logic [IDX_W-1:0]  idx_o
);
    // Non-selected lanes contribute zero so the top can OR-reduce.
    assign data_o = hot_i ? lane_i : '0;
    assign idx_o  = hot_i ? IDX_W'(IDX) : '0;
endmodule

module lane_scatter #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic           CLK,
    input  logic           ASYNCRESETN,
    lane_scatter_if.slave  bus
);
    localparam int IDX_W = $clog2(LANES);

    logic [LANES-1:0][LANE_W-1:0] word_q, word_d;
    logic [LANES-1:0]             rem_q, rem_d;
    logic [7:0]                   drop_q, drop_d;

    logic [LANES-1:0]             low_hot;
    logic                         busy;
    logic                         single;
    logic                         out_hs;
    logic                         in_rdy;
    logic                         accept;

    logic [LANES-1:0][LANE_W-1:0] pick_data;
    logic [LANES-1:0][IDX_W-1:0]  pick_idx;
    logic [LANE_W-1:0]            sel_data;
    logic [IDX_W-1:0]             sel_idx;

    // Isolate the lowest pending lane; zero when nothing is pending.
    assign low_hot = rem_q & (~rem_q + LANES'(1));
    assign busy    = |rem_q;
    assign single  = busy && ((rem_q & (rem_q - LANES'(1))) == '0);
    assign out_hs  = busy && bus.out_ready;
    // Held low while in reset so nothing is taken before the block is live.
    assign in_rdy  = ASYNCRESETN && (!busy || (out_hs && single));
    assign accept  = bus.in_valid && in_rdy;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_scatter_pick #(
            .LANE_W (LANE_W),
            .IDX_W  (IDX_W),
            .IDX    (k)
        ) u_pick (
            .hot_i  (low_hot[k]),
            .lane_i (word_q[k]),
            .data_o (pick_data[k]),
            .idx_o  (pick_idx[k])
        );
    end

    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int k = 0; k < LANES; k++) begin
            sel_data = sel_data | pick_data[k];
            sel_idx  = sel_idx  | pick_idx[k];
        end
    end

    // A new word overrides the last-lane clear so words stream without a gap.
    always_comb begin
        word_d = word_q;
        rem_d  = rem_q;
        drop_d = drop_q;
        if (out_hs)
            rem_d = rem_q & ~low_hot;
        if (accept) begin
            word_d = bus.in_data;
            rem_d  = bus.in_mask;
            if (bus.in_mask == '0 && drop_q != 8'hFF)
                drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            word_q <= '0;
            rem_q  <= '0;
            drop_q <= '0;
        end else begin
            word_q <= word_d;
            rem_q  <= rem_d;
            drop_q <= drop_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = busy;
    assign bus.out_data  = sel_data;
    assign bus.out_idx   = sel_idx;
    assign bus.out_last  = single;
    assign bus.drop_cnt  = drop_q;
endmodule
